// File: rtl/qbert_timer_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
// Imported by the channel and top-level modules.
package qbert_timer_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;
    localparam logic [2:0] REG_PRESCALE = 3'd6;
    localparam logic [2:0] REG_IRQ_PEND = 3'd7;

    localparam int CTL_ITO    = 0;
    localparam int CTL_CONT   = 1;
    localparam int CTL_START  = 2;
    localparam int CTL_STOP   = 3;
    localparam int CTL_PRE_EN = 4;

    localparam int ST_TO  = 0;
    localparam int ST_RUN = 1;

endpackage

// File: rtl/qbert_timer_channel.sv
// One timer channel: period, prescaler, down-counter, RUN/TO flags, snapshot.
// Presents a 16-bit read word for each register offset.
module qbert_timer_channel
    import qbert_timer_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int PRE_W        = 8,
    parameter int RESET_PERIOD = 49999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [2:0]       reg_sel,
    input  logic [15:0]      wdata,
    output logic [7:0][15:0] rd_words,
    output logic             irq
);

    localparam int HI_W = CNT_W - 16;
    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(RESET_PERIOD);

    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] snapshot;
    logic [PRE_W-1:0] prescale;
    logic [PRE_W-1:0] pre_cnt;
    logic             ito;
    logic             cont;
    logic             pre_en;
    logic             run;
    logic             to;
    logic             reload_pend;

    logic wr_status;
    logic wr_ctl;
    logic wr_pl;
    logic wr_ph;
    logic wr_snap;
    logic wr_pre;
    logic start;
    logic stop;
    logic pre_zero;
    logic tick;
    logic expire;

    assign wr_status = we && (reg_sel == REG_STATUS);
    assign wr_ctl    = we && (reg_sel == REG_CONTROL);
    assign wr_pl     = we && (reg_sel == REG_PERIOD_L);
    assign wr_ph     = we && (reg_sel == REG_PERIOD_H);
    assign wr_pre    = we && (reg_sel == REG_PRESCALE);
    assign wr_snap   = we && ((reg_sel == REG_SNAP_L) || (reg_sel == REG_SNAP_H));
    assign start     = wr_ctl && wdata[CTL_START];
    assign stop      = wr_ctl && wdata[CTL_STOP];

    assign pre_zero = (pre_cnt == '0);
    assign tick     = run && (!pre_en || pre_zero);
    // A pending forced reload owns the counter, so no timeout that cycle.
    assign expire   = tick && (counter == '0) && !reload_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            period      <= RST_VAL;
            counter     <= RST_VAL;
            snapshot    <= '0;
            prescale    <= '0;
            pre_cnt     <= '0;
            ito         <= 1'b0;
            cont        <= 1'b0;
            pre_en      <= 1'b0;
            run         <= 1'b0;
            to          <= 1'b0;
            reload_pend <= 1'b0;
        end else begin
            if (wr_ctl) begin
                ito    <= wdata[CTL_ITO];
                cont   <= wdata[CTL_CONT];
                pre_en <= wdata[CTL_PRE_EN];
            end
            if (wr_pl)
                period[15:0] <= wdata;
            if (wr_ph)
                period[CNT_W-1:16] <= wdata[HI_W-1:0];
            if (wr_pre)
                prescale <= wdata[PRE_W-1:0];
            if (wr_snap)
                snapshot <= counter;

            reload_pend <= wr_pl || wr_ph;

            if (start)
                pre_cnt <= prescale;
            else if (run && pre_en)
                pre_cnt <= pre_zero ? prescale : pre_cnt - PRE_W'(1);

            if (reload_pend)
                counter <= period;
            else if (tick)
                counter <= (counter == '0) ? period : counter - CNT_W'(1);

            if (reload_pend)
                run <= 1'b0;
            else if (start)
                run <= 1'b1;
            else if (stop)
                run <= 1'b0;
            else if (expire && !cont)
                run <= 1'b0;

            if (wr_status)
                to <= 1'b0;
            else if (expire)
                to <= 1'b1;
        end
    end

    always_comb begin
        rd_words = '0;
        rd_words[REG_STATUS][ST_TO]       = to;
        rd_words[REG_STATUS][ST_RUN]      = run;
        rd_words[REG_CONTROL][CTL_ITO]    = ito;
        rd_words[REG_CONTROL][CTL_CONT]   = cont;
        rd_words[REG_CONTROL][CTL_PRE_EN] = pre_en;
        rd_words[REG_PERIOD_L] = period[15:0];
        rd_words[REG_PERIOD_H] = 16'(period[CNT_W-1:16]);
        rd_words[REG_SNAP_L]   = snapshot[15:0];
        rd_words[REG_SNAP_H]   = 16'(snapshot[CNT_W-1:16]);
        rd_words[REG_PRESCALE] = 16'(prescale);
    end

    assign irq = to && ito;

endmodule

// File: rtl/qbert_multi_timer.sv
// Multi-channel interval timer on a 16-bit Avalon-MM slave.
// Address = {channel, reg}; registered read data; combined IRQ.
module qbert_multi_timer
    import qbert_timer_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int PRE_W        = 8,
    parameter int RESET_PERIOD = 49999
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3+$clog2(NUM_CH)-1:0]  address,
    input  logic                         chipselect,
    input  logic                         write_n,
    input  logic [15:0]                  writedata,
    output logic [15:0]                  readdata,
    output logic                         irq,
    output logic [NUM_CH-1:0]            irq_vec
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int SEL_W = (CH_W > 0) ? CH_W : 1;

    logic [2:0]       reg_sel;
    logic [SEL_W-1:0] ch_sel;
    logic             wr;
    logic [15:0]      rd_mux;
    logic [7:0][15:0] words [NUM_CH];

    assign reg_sel = address[2:0];
    assign wr      = chipselect && !write_n;

    generate
        if (CH_W > 0) begin : g_sel
            assign ch_sel = address[CH_W+2:3];
        end else begin : g_nosel
            assign ch_sel = '0;
        end
    endgenerate

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        qbert_timer_channel #(
            .CNT_W        (CNT_W),
            .PRE_W        (PRE_W),
            .RESET_PERIOD (RESET_PERIOD)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .we       (wr && (ch_sel == SEL_W'(i))),
            .reg_sel  (reg_sel),
            .wdata    (writedata),
            .rd_words (words[i]),
            .irq      (irq_vec[i])
        );
    end

    // IRQ_PEND is shared, so it reads the same at every channel index.
    always_comb begin
        rd_mux = '0;
        if (reg_sel == REG_IRQ_PEND) begin
            rd_mux = 16'(irq_vec);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_sel == SEL_W'(i))
                    rd_mux = words[i][reg_sel];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            readdata <= '0;
        else
            readdata <= rd_mux;
    end

    assign irq = |irq_vec;

endmodule
